// File: rtl/block_lock_aligner.sv
// 64b/66b receive block aligner: bit-slip hunt for the sync-header boundary, lock FSM, aligned output.
// Define BLOCK_LOCK_STAT_EN to add the saturating slip_count / lock_loss_count statistics ports.
module block_lock_aligner #(
    parameter int LOCK_CNT    = 64,
    parameter int WINDOW      = 64,
    parameter int INVALID_MAX = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [65:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [1:0]  m_axis_ttype,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        block_lock
`ifdef BLOCK_LOCK_STAT_EN
    ,
    output logic [15:0] slip_count,
    output logic [15:0] lock_loss_count
`endif
);

    localparam int SH_W  = $clog2(LOCK_CNT + 1);
    localparam int WIN_W = $clog2(WINDOW + 1);
    localparam int INV_W = $clog2(INVALID_MAX + 1);

    localparam logic [SH_W-1:0]  SH_LAST_M1  = SH_W'(LOCK_CNT - 1);
    localparam logic [WIN_W-1:0] WIN_LAST_M1 = WIN_W'(WINDOW - 1);
    localparam logic [INV_W-1:0] INV_LAST_M1 = INV_W'(INVALID_MAX - 1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [65:0]      prev;
    logic [6:0]       offset, offset_nxt;
    logic [SH_W-1:0]  sh_cnt, sh_cnt_nxt;
    logic [WIN_W-1:0] win_cnt, win_cnt_nxt;
    logic [INV_W-1:0] invld_cnt, invld_cnt_nxt;

    logic        accept;
    logic [65:0] win;
    logic        hdr_valid;
    logic        slip;
    logic        lock_lost;

    assign s_axis_tready = !reset && (!m_axis_tvalid || m_axis_tready);
    assign accept        = s_axis_tvalid && s_axis_tready;
    // The window straddles the previous and current word; offset 0 selects the previous word.
    assign win           = 66'({s_axis_tdata, prev} >> offset);
    assign hdr_valid     = win[1] ^ win[0];
    assign block_lock    = (state == LOCKED);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        state_nxt     = state;
        offset_nxt    = offset;
        sh_cnt_nxt    = sh_cnt;
        win_cnt_nxt   = win_cnt;
        invld_cnt_nxt = invld_cnt;
        slip          = 1'b0;
        lock_lost     = 1'b0;

        if (accept) begin
            case (state)
                HUNT: begin
                    if (hdr_valid) begin
                        if (sh_cnt == SH_LAST_M1) begin
                            state_nxt     = LOCKED;
                            sh_cnt_nxt    = '0;
                            win_cnt_nxt   = '0;
                            invld_cnt_nxt = '0;
                        end else begin
                            sh_cnt_nxt = sh_cnt + 1'b1;
                        end
                    end else begin
                        slip       = 1'b1;
                        sh_cnt_nxt = '0;
                    end
                end
                LOCKED: begin
                    // Loss of lock wins over a coincident window end.
                    if (!hdr_valid && invld_cnt == INV_LAST_M1) begin
                        state_nxt     = HUNT;
                        slip          = 1'b1;
                        lock_lost     = 1'b1;
                        sh_cnt_nxt    = '0;
                        win_cnt_nxt   = '0;
                        invld_cnt_nxt = '0;
                    end else if (win_cnt == WIN_LAST_M1) begin
                        win_cnt_nxt   = '0;
                        invld_cnt_nxt = '0;
                    end else begin
                        win_cnt_nxt   = win_cnt + 1'b1;
                        invld_cnt_nxt = invld_cnt + INV_W'(!hdr_valid);
                    end
                end
            endcase

            if (slip) begin
                offset_nxt = (offset == 7'd65) ? 7'd0 : offset + 7'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            state     <= HUNT;
            offset    <= '0;
            sh_cnt    <= '0;
            win_cnt   <= '0;
            invld_cnt <= '0;
        end else begin
            state     <= state_nxt;
            offset    <= offset_nxt;
            sh_cnt    <= sh_cnt_nxt;
            win_cnt   <= win_cnt_nxt;
            invld_cnt <= invld_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev          <= '0;
            m_axis_ttype  <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
        end else if (accept) begin
            prev          <= s_axis_tdata;
            m_axis_ttype  <= win[1:0];
            m_axis_tdata  <= win[65:2];
            // The lock-completing block is dropped; the lock-losing block is still forwarded.
            m_axis_tvalid <= (state == LOCKED);
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

`ifdef BLOCK_LOCK_STAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            slip_count      <= '0;
            lock_loss_count <= '0;
        end else begin
            if (slip && slip_count != 16'hFFFF) begin
                slip_count <= slip_count + 16'd1;
            end
            if (lock_lost && lock_loss_count != 16'hFFFF) begin
                lock_loss_count <= lock_loss_count + 16'd1;
            end
        end
    end
`endif

endmodule
